// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl
// Duty-cycle sequencer for the PWM generator. Accepts a target duty over a
// valid/ready handshake and walks the duty output toward it one LSB at a
// time. Each step waits for step_div+1 PWM period boundaries, so the PWM
// core only ever sees a duty change at a period wrap.

module pwm_duty_ramp_ctrl #(
    parameter int unsigned BITS_DUTY = 5,
    parameter int unsigned DIV_W     = 4
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 period_end,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [BITS_DUTY:0]   tgt_duty,
    input  logic [DIV_W-1:0]     step_div,
    output logic [BITS_DUTY:0]   duty,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned DUTY_W = BITS_DUTY + 1;

    // Full-on duty: 2**BITS_DUTY, the top of the legal range.
    localparam logic [DUTY_W-1:0] FULL_DUTY = {1'b1, {BITS_DUTY{1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRampUp,
        StRampDown
    } state_t;

    state_t             state_q, state_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [DUTY_W-1:0]  tgt_q, tgt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   pcnt_q, pcnt_d;
    logic               done_q, done_d;

    logic               accept;
    logic               tick;
    logic               step_now;
    logic [DUTY_W-1:0]  tgt_clamped;
    logic [DUTY_W-1:0]  duty_stepped;

    // Handshake and clamp of the requested target to full-on.
    always_comb begin
        tgt_ready   = en && (state_q == StIdle);
        accept      = tgt_valid && tgt_ready;
        tgt_clamped = (tgt_duty > FULL_DUTY) ? FULL_DUTY : tgt_duty;
    end

    // Step timing: a period boundary counts only while enabled and ramping;
    // the step fires when the period counter has reached the latched divider.
    always_comb begin
        tick     = en && period_end && (state_q != StIdle);
        step_now = tick && (pcnt_q == div_q);
        if (state_q == StRampDown) begin
            duty_stepped = duty_q - DUTY_W'(1);
        end else begin
            duty_stepped = duty_q + DUTY_W'(1);
        end
    end

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        div_d   = div_q;
        pcnt_d  = pcnt_q;
        // done is a single-cycle pulse and clears even while disabled.
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tgt_d  = tgt_clamped;
                    div_d  = step_div;
                    pcnt_d = '0;
                    if (tgt_clamped > duty_q) begin
                        state_d = StRampUp;
                    end else if (tgt_clamped < duty_q) begin
                        state_d = StRampDown;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            StRampUp, StRampDown: begin
                if (step_now) begin
                    duty_d = duty_stepped;
                    pcnt_d = '0;
                    // Stepping by one from the correct side of the target
                    // lands exactly on it, so equality is the only exit.
                    if (duty_stepped == tgt_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else if (tick) begin
                    pcnt_d = pcnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            duty_q  <= '0;
            tgt_q   <= '0;
            div_q   <= '0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            div_q   <= div_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
        end
    end

    // Output mapping.
    always_comb begin
        duty = duty_q;
        busy = (state_q != StIdle);
        done = done_q;
    end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl: reset, ramps up/down with dividers,
// clamping, no-op target, enable freeze, mid-ramp target rejection and a
// period_end coinciding with acceptance. Inputs change and outputs are
// sampled on the falling clock edge.

module tb_pwm_duty_ramp_ctrl;

    logic       clk_in;
    logic       rst;
    logic       en;
    logic       period_end;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [5:0] tgt_duty;
    logic [3:0] step_div;
    logic [5:0] duty;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_err;
    int np;

    pwm_duty_ramp_ctrl #(
        .BITS_DUTY (5),
        .DIV_W     (4)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .period_end (period_end),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_duty   (tgt_duty),
        .step_div   (step_div),
        .duty       (duty),
        .busy       (busy),
        .done       (done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: through the rising edge, back to the falling edge.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic gap();
        repeat (2) tick();
    endtask

    task automatic pe();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic accept(input int tgt, input int div);
        tgt_valid = 1'b1;
        tgt_duty  = 6'(tgt);
        step_div  = 4'(div);
        tick();
        tgt_valid = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        en         = 1'b0;
        period_end = 1'b0;
        tgt_valid  = 1'b0;
        tgt_duty   = '0;
        step_div   = '0;

        // Reset state, before any clock edge.
        #1;
        check_eq("rst_duty", int'(duty), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_ready_en0", int'(tgt_ready), 0);
        @(negedge clk_in);
        rst = 1'b0;
        en  = 1'b1;
        #1;
        check_eq("ready_after_rst", int'(tgt_ready), 1);

        // Ramp up 0 -> 5, step_div = 0.
        accept(5, 0);
        check_eq("up_busy_accept", int'(busy), 1);
        check_eq("up_duty_accept", int'(duty), 0);
        for (int i = 1; i <= 5; i++) begin
            gap();
            check_eq("up_hold_no_pe", int'(duty), i - 1);
            pe();
            check_eq("up_duty", int'(duty), i);
            check_eq("up_done", int'(done), (i == 5) ? 1 : 0);
            check_eq("up_busy", int'(busy), (i == 5) ? 0 : 1);
        end
        tick();
        check_eq("up_done_clears", int'(done), 0);

        // Ramp down 5 -> 3, step_div = 2.
        accept(3, 2);
        check_eq("dn_busy_accept", int'(busy), 1);
        for (int i = 1; i <= 6; i++) begin
            gap();
            pe();
            check_eq("dn_duty", int'(duty), (i < 3) ? 5 : ((i < 6) ? 4 : 3));
            check_eq("dn_done", int'(done), (i == 6) ? 1 : 0);
        end

        // Clamp: target 40 -> ramp ends at 32 after 29 pulses.
        accept(40, 0);
        check_eq("clamp_busy", int'(busy), 1);
        np = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            gap();
            pe();
            np++;
        end
        check_eq("clamp_pulses", np, 29);
        check_eq("clamp_duty", int'(duty), 32);
        check_eq("clamp_done", int'(done), 1);
        check_eq("ready_in_done_cycle", int'(tgt_ready), 1);

        // No-op: target equals current duty, accepted in the done cycle.
        accept(32, 0);
        check_eq("noop_busy", int'(busy), 0);
        check_eq("noop_done", int'(done), 1);
        check_eq("noop_duty", int'(duty), 32);
        en = 1'b0;
        tick();
        check_eq("done_clears_en0", int'(done), 0);
        check_eq("ready_en0", int'(tgt_ready), 0);
        en = 1'b1;

        // Enable freeze mid-ramp: 32 -> 28, step_div = 1.
        accept(28, 1);
        pe();
        check_eq("frz_d1", int'(duty), 32);
        pe();
        check_eq("frz_d2", int'(duty), 31);
        pe();
        check_eq("frz_d3", int'(duty), 31);
        en = 1'b0;
        #1;
        check_eq("frz_ready", int'(tgt_ready), 0);
        for (int i = 0; i < 3; i++) begin
            gap();
            pe();
        end
        check_eq("frz_duty_held", int'(duty), 31);
        check_eq("frz_busy_held", int'(busy), 1);
        en = 1'b1;
        pe();
        check_eq("frz_resume", int'(duty), 30);
        for (int i = 0; i < 4; i++) begin
            gap();
            pe();
        end
        check_eq("frz_end_duty", int'(duty), 28);
        check_eq("frz_end_done", int'(done), 1);
        check_eq("frz_end_busy", int'(busy), 0);

        // Reset mid-ramp at duty 7 (ramping 28 -> 5).
        accept(5, 0);
        for (int k = 0; k < 30 && duty != 6'd7; k++) begin
            pe();
        end
        check_eq("mrst_pre_duty", int'(duty), 7);
        rst = 1'b1;
        #1;
        check_eq("mrst_duty", int'(duty), 0);
        check_eq("mrst_busy", int'(busy), 0);
        check_eq("mrst_done", int'(done), 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("mrst_ready", int'(tgt_ready), 1);

        // Mid-ramp target ignored: ramp 0 -> 10 with tgt_valid=0-value offered.
        accept(10, 0);
        for (int i = 0; i < 3; i++) pe();
        check_eq("ign_d3", int'(duty), 3);
        tgt_valid = 1'b1;
        tgt_duty  = 6'd0;
        #1;
        check_eq("ign_ready", int'(tgt_ready), 0);
        np = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            gap();
            pe();
            np++;
        end
        tgt_valid = 1'b0;
        check_eq("ign_pulses", np, 7);
        check_eq("ign_duty", int'(duty), 10);
        check_eq("ign_done", int'(done), 1);

        // period_end on the acceptance edge does not count toward the step.
        period_end = 1'b1;
        accept(12, 1);
        period_end = 1'b0;
        check_eq("sim_busy", int'(busy), 1);
        check_eq("sim_duty0", int'(duty), 10);
        gap();
        pe();
        check_eq("sim_duty1", int'(duty), 10);
        gap();
        pe();
        check_eq("sim_duty2", int'(duty), 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
# pwm_duty_ramp_ctrl

Duty-cycle sequencer for the team's PWM generator. It accepts a target duty through a valid/ready handshake and ramps its `duty` output toward that target one LSB at a time. The ramp rate is programmable in whole PWM periods. `duty` drives the PWM core's duty input, and updates land only on PWM period boundaries so the core never sees a mid-period change.

## Interface

**Parameters**
- `BITS_DUTY`, default 5: PWM counter width. The duty bus is `BITS_DUTY+1` bits wide, with a legal range of 0..2**BITS_DUTY.
- `DIV_W`, default 4: width of the step divider input.

**Ports**
- `clk_in`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: block enable. When low, all state is frozen.
- `period_end`, in, 1: one-cycle pulse from the PWM core on the cycle its counter equals 2**BITS_DUTY-1 (the wrap cycle).
- `tgt_valid`, in, 1: a new target is offered.
- `tgt_ready`, out, 1: the block can accept a target. Combinational: `en && state==IDLE`.
- `tgt_duty`, in, BITS_DUTY+1: requested duty.
- `step_div`, in, DIV_W: a step occurs every `step_div+1` period_end pulses. Sampled at acceptance.
- `duty`, out, BITS_DUTY+1: registered duty, fed to the PWM core.
- `busy`, out, 1: `state != IDLE`.
- `done`, out, 1: registered one-cycle pulse when `duty` reaches the target.

## Operation

**States**
- IDLE, RAMP_UP, RAMP_DOWN.

**Acceptance**
- A target is accepted on a rising `clk_in` edge with `tgt_valid && tgt_ready`.
- The latched target is `min(tgt_duty, 2**BITS_DUTY)`. Any value above 2**BITS_DUTY clamps to full-on.
- `step_div` is latched and the period counter `pcnt` is cleared.
- Next state depends on the latched target:
  - target > duty: RAMP_UP.
  - target < duty: RAMP_DOWN.
  - target == duty: stay in IDLE and assert `done` for the next cycle.
- `tgt_valid` outside IDLE is ignored. There is no retargeting mid-ramp; no queueing.

**In RAMP_UP / RAMP_DOWN, on each edge with `en && period_end`**
- If `pcnt == step_div_latched`: `duty` moves ±1 toward the target and `pcnt` returns to 0.
- Otherwise: `pcnt` increments.
- If the stepped `duty` equals the target, then on that same edge:
  - state goes to IDLE;
  - `done` goes to 1 for exactly one cycle.

**Enable and reset**
- `en` low: `period_end` is ignored and `tgt_ready` is 0. `duty`, `pcnt`, state and latched values all hold. `done` still clears after its one cycle.
- `rst` asserted at any time, including mid-ramp, immediately sets:
  - `duty` = 0, state = IDLE, `pcnt` = 0, `done` = 0, `busy` = 0;
  - latched target = 0, latched divider = 0.
- `tgt_ready` follows `en` after reset.

**Arithmetic**
- `duty` never leaves 0..2**BITS_DUTY. Stepping is strictly by 1 and never overshoots the target.
- `pcnt` is DIV_W bits wide and never exceeds `step_div_latched`.

## Timing

- Acceptance to state change: 1 clock.
- Acceptance to first `duty` change: exactly `step_div+1` period_end pulses. The change lands on the clock edge where the final pulse is high.
- Total ramp length: `|target - duty_at_accept| × (step_div+1)` period_end pulses.
- `duty` changes only on edges where `period_end` is high. The PWM core registers its compare output, so the new duty governs the whole following period.
- `done` is high in the same cycle that `duty` first equals the target and `busy` is 0.
- A new target may be accepted in the cycle `done` is high, since `tgt_ready` is already 1.
- Simultaneous `tgt_valid` and `period_end` in IDLE: only the acceptance occurs. That `period_end` does not count toward the first step.

## Test plan

- **Reset:** hold `rst` high mid-ramp with duty=7 → `duty`=0, `busy`=0, `done`=0 immediately without a clock; `tgt_ready`=1 once `rst` falls with `en`=1.
- **Ramp up, step_div=0:** target 5 from 0, `period_end` every 32 cycles → duty goes 1,2,3,4,5 on consecutive pulses; `done` pulses once with duty=5; `busy` falls the same cycle.
- **Ramp down, step_div=2:** from 5, target 3 → duty=4 after the 3rd pulse and 3 after the 6th; `done` fires on the 6th pulse edge.
- **Clamp and no-op:** target 40 with BITS_DUTY=5 → ramp ends at 32. Target equal to current duty → `busy` stays 0 and `done`=1 the cycle after acceptance.
- **Enable freeze:** drop `en` for 3 `period_end` pulses mid-ramp → `duty`/`pcnt` unchanged and `tgt_ready`=0; the ramp resumes from the same point when `en` returns.
- **Mid-ramp target ignored:** assert `tgt_valid` with value 0 during RAMP_UP toward 10 → no acceptance, ramp still ends at 10.
